// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types for the instruction-memory responder:
//   imem_state_e : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   imem_req_t   : latched fetch request (byte address)
//   imem_rsp_t   : response bundle (instruction word, misalignment flag)
// Struct fields are sized for the widest supported configuration; the top
// zero-extends into them and truncates back to its own parameter widths.
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_MAX_ADDR_W = 32;
    localparam int IMEM_MAX_DATA_W = 64;
    localparam int IMEM_CNT_W      = 4;   // holds WAIT_STATES-1 for 0..15

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    typedef struct packed {
        logic [IMEM_MAX_ADDR_W-1:0] addr;
    } imem_req_t;

    typedef struct packed {
        logic [IMEM_MAX_DATA_W-1:0] inst;
        logic                       err;
    } imem_rsp_t;

    // Byte address to word index; callers truncate to their array depth,
    // which is what makes out-of-range addresses wrap.
    function automatic logic [IMEM_MAX_ADDR_W-1:0] imem_word_index(
        input logic [IMEM_MAX_ADDR_W-1:0] byte_addr
    );
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// Word-addressed instruction storage: one synchronous write port and one
// registered read port. Reading and writing the same word on one edge returns
// the old contents.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (read register only)
//   we_i     : write strobe
//   waddr_i  : write word index
//   wdata_i  : write data
//   re_i     : read strobe; captures mem[raddr_i] into rdata_o
//   raddr_i  : read word index
//   rdata_o  : registered read data (held until the next read)
// -----------------------------------------------------------------------------
module imem_array #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 256,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: storage has no reset so it maps onto RAM and keeps the loaded
    // program across a responder reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // NOTE: non-blocking assignments make the read sample mem_q before the
    // write above lands, giving read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction-memory responder: accepts one fetch at a time, waits
// WAIT_STATES cycles, then presents the fetched word until the fetch stage
// takes it. A separate program-load port writes memory in any state.
// Optional macro: IMEM_MISALIGN_CHECK_EN -- flag fetches with addr[1:0] != 0
// through rsp_err and return a zero instruction for them.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : fetch request present
//   req_ready  : responder idle and able to accept
//   req_addr   : fetch byte address (latched on accept)
//   rsp_valid  : response data valid
//   rsp_ready  : fetch stage consumes the response
//   rsp_inst   : instruction word
//   rsp_err    : misaligned-fetch flag
//   load_en    : program-load write strobe
//   load_addr  : program-load byte address (bits [1:0] ignored)
//   load_data  : program-load word
// -----------------------------------------------------------------------------
module imem_responder
    import imem_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int IMEM_SZ_IN_KB = 1,
    parameter  int WAIT_STATES   = 1,
    localparam int ADDR_WIDTH    = $clog2(IMEM_SZ_IN_KB * 1024)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_inst,
    output logic                  rsp_err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int DEPTH = IMEM_SZ_IN_KB * 256;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IMEM_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? IMEM_CNT_W'(WAIT_STATES - 1) : '0;

    imem_state_e           state_q, state_d;
    logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
    imem_req_t             req_q, req_d;
    imem_req_t             cap_req;     // address used for the capture this edge
    logic                  rd_en;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    imem_rsp_t             rsp;

    assign req_ready = (state_q == IMEM_IDLE) && !rst;

    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        cap_req = req_q;
        rd_en   = 1'b0;
        case (state_q)
            IMEM_IDLE: begin
                if (req_valid && req_ready) begin
                    req_d.addr = IMEM_MAX_ADDR_W'(req_addr);
                    if (WAIT_STATES == 0) begin
                        // No wait states: capture straight from the port.
                        state_d = IMEM_RESP;
                        rd_en   = 1'b1;
                        cap_req = req_d;
                    end else begin
                        state_d = IMEM_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            IMEM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IMEM_RESP;
                    rd_en   = 1'b1;
                end else begin
                    cnt_d = cnt_q - IMEM_CNT_W'(1);
                end
            end
            IMEM_RESP: begin
                if (rsp_ready) begin
                    state_d = IMEM_IDLE;
                end
            end
            default: begin
                state_d = IMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IMEM_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Truncating the word index to the array depth wraps out-of-range
    // addresses onto the array.
    assign rd_idx = IDX_W'(imem_word_index(cap_req.addr));
    assign wr_idx = IDX_W'(imem_word_index(IMEM_MAX_ADDR_W'(load_addr)));

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (load_en),
        .waddr_i (wr_idx),
        .wdata_i (load_data),
        .re_i    (rd_en),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

`ifdef IMEM_MISALIGN_CHECK_EN
    logic err_q, err_d;

    // Error is captured alongside the read so it stays aligned with rsp_inst.
    always_comb begin
        err_d = err_q;
        if (rd_en) begin
            err_d = (cap_req.addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    always_comb begin
        rsp      = '0;
        rsp.inst = IMEM_MAX_DATA_W'(rd_data);
`ifdef IMEM_MISALIGN_CHECK_EN
        rsp.err = err_q;
        if (err_q) begin
            rsp.inst = '0;
        end
`endif
    end

    assign rsp_valid = (state_q == IMEM_RESP) && !rst;
    assign rsp_inst  = rsp.inst[DATA_WIDTH-1:0];
    assign rsp_err   = rsp.err;

endmodule
